// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared constants for the bit-serial adder: FSM state encoding and the
//   default operand width.
package serial_adder_pkg;

    // 2'd3 is unused and is treated as IDLE by the FSM.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// FA_str
//   1-bit structural full adder built from gate primitives.
//   Ports: c_out (carry out), sum (sum bit), a, b (operand bits), c_in (carry in).
module FA_str (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    logic axb, g_ab, g_pc;

    xor u_x1 (axb,   a,   b);
    xor u_x2 (sum,   axb, c_in);
    and u_a1 (g_ab,  a,   b);
    and u_a2 (g_pc,  axb, c_in);
    or  u_o1 (c_out, g_ab, g_pc);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial W-bit adder. One FA_str cell adds the operands LSB-first, one
//   bit per clock, with the carry held in a flip-flop between bits.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             request, sampled only in IDLE
//     a, b, c_in        operands / carry-in, captured on the accepting edge
//     busy              high in RUN and DONE
//     done              one-cycle pulse when the result becomes valid
//     sum, c_out        result mod 2^W and carry out of the MSB (held)
//     overflow          signed overflow of the last result (held)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int W  = SA_W_DEFAULT,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam logic [CW-1:0] CNT_PRE  = CW'(W - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    state_q;
    logic [W-1:0]  sh_a_q, sh_b_q, sh_r_q;
    logic [W-1:0]  sum_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q, c_msb_q;
    logic          done_q, c_out_q, ovf_q;

    logic          fa_s, fa_co;
    logic [W-1:0]  sh_r_d;

    FA_str u_fa (
        .c_out (fa_co),
        .sum   (fa_s),
        .a     (sh_a_q[0]),
        .b     (sh_b_q[0]),
        .c_in  (carry_q)
    );

    // Result register fills from the top so bit 0 lands at the LSB after W shifts.
    assign sh_r_d = {fa_s, sh_r_q[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_r_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    sh_a_q  <= sh_a_q >> 1;
                    sh_b_q  <= sh_b_q >> 1;
                    sh_r_q  <= sh_r_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    // Carry leaving bit W-2 is the carry into the MSB.
                    if (cnt_q == CNT_PRE) c_msb_q <= fa_co;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        sum_q   <= sh_r_d;
                        c_out_q <= fa_co;
                        ovf_q   <= c_msb_q ^ fa_co;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        sh_a_q  <= a;
                        sh_b_q  <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // W=8 instance
    logic       start8, ci8, busy8, done8, co8, ov8;
    logic [7:0] a8, b8, sum8;
    // W=4 instance
    logic       start4, ci4, busy4, done4, co4, ov4;
    logic [3:0] a4, b4, sum4;

    serial_adder #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .overflow(ov8)
    );

    serial_adder #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(co4), .overflow(ov4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
    task automatic ref_add(input int w, input int ia, input int ib, input int ic,
                           output int s, output int co, output int ov);
        int tot, sa, sb, ss;
        tot = ia + ib + ic;
        s   = tot % (1 << w);
        co  = tot >> w;
        sa  = (ia >= (1 << (w - 1))) ? ia - (1 << w) : ia;
        sb  = (ib >= (1 << (w - 1))) ? ib - (1 << w) : ib;
        ss  = sa + sb + ic;
        ov  = (ss > (1 << (w - 1)) - 1 || ss < -(1 << (w - 1))) ? 1 : 0;
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       output logic [7:0] s, output logic co, output logic ov, output int lat);
        logic [7:0] s_prev;
        logic       co_prev, ov_prev, hold_ok;
        @(negedge clk);
        a8 = ia; b8 = ib; ci8 = ic; start8 = 1'b1;
        s_prev = sum8; co_prev = co8; ov_prev = ov8;
        @(negedge clk);
        start8 = 1'b0;
        // Operands are scrambled after accept; result must not depend on them.
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        lat = 0; hold_ok = 1'b1;
        while (!done8 && lat < 20) begin
            if (sum8 !== s_prev || co8 !== co_prev || ov8 !== ov_prev || busy8 !== 1'b1)
                hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("hold_during_run", 32'(hold_ok), 32'd1);
        s = sum8; co = co8; ov = ov8;
        @(negedge clk);
        chk("done_one_cycle", 32'(done8), 32'd0);
    endtask

    task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                       output logic [3:0] s, output logic co, output logic ov, output logic ok);
        int n;
        @(negedge clk);
        a4 = ia; b4 = ib; ci4 = ic; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 12) begin
            @(negedge clk);
            n++;
        end
        ok = (n == 4);
        s = sum4; co = co4; ov = ov4;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [7:0] s;
        logic       co, ov, ok;
        logic [3:0] s4;
        int         lat, es, eco, eov, rise0, rise1, ndone, done_i, idle_i;
        logic       prev_busy;
        int         n4_err;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'hC0, 8'hB0, 1'b1, 8'h71, 1'b1, 1'b1};

        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; ci8 = 0;
        start4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        #22;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_sum",  32'(sum8),  0);
        chk("rst_cout", 32'(co8),   0);
        chk("rst_ovf",  32'(ov8),   0);
        chk("rst_busy4", 32'(busy4), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].ci, s, co, ov, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd8);
            chk($sformatf("tbl%0d_sum", i), 32'(s),  32'(tbl[i].s));
            chk($sformatf("tbl%0d_co", i),  32'(co), 32'(tbl[i].co));
            chk($sformatf("tbl%0d_ov", i),  32'(ov), 32'(tbl[i].ov));
        end

        // start held high: back-to-back accepts every W+2 cycles
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; ci8 = 0; start8 = 1'b1;
        rise0 = -1; rise1 = -1; done_i = -1; idle_i = -1; prev_busy = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy8 && !prev_busy) begin
                if (rise0 < 0) rise0 = i; else if (rise1 < 0) rise1 = i;
            end
            if (!busy8 && idle_i < 0 && rise0 >= 0) idle_i = i;
            if (done8 && done_i < 0) begin
                done_i = i;
                chk("held_sum", 32'(sum8), 32'h00);
                chk("held_co",  32'(co8),  32'd1);
                chk("held_ov",  32'(ov8),  32'd1);
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        chk("held_first_accept", 32'(rise0), 32'd0);
        chk("held_period", 32'(rise1 - rise0), 32'd10);
        chk("held_idle_after_done", 32'(idle_i - done_i), 32'd1);
        repeat (12) @(negedge clk);

        // Operand change and start pulse during RUN are ignored
        a8 = 8'h5A; b8 = 8'h33; ci8 = 0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                ndone++;
                chk("midrun_sum", 32'(sum8), 32'h8D);
                chk("midrun_co",  32'(co8),  32'd0);
                chk("midrun_ov",  32'(ov8),  32'd1);
            end
            @(negedge clk);
        end
        chk("midrun_done_count", 32'(ndone), 32'd1);
        chk("midrun_idle", 32'(busy8), 32'd0);

        // Reset pulse at cnt=3 aborts; outputs clear immediately
        a8 = 8'h11; b8 = 8'h22; ci8 = 0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_done", 32'(done8), 0);
        chk("abort_sum",  32'(sum8),  0);
        chk("abort_co",   32'(co8),   0);
        chk("abort_ov",   32'(ov8),   0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 0);
        op8(8'h5A, 8'h33, 1'b0, s, co, ov, lat);
        chk("post_abort_lat", 32'(lat), 32'd8);
        chk("post_abort_sum", 32'(s),   32'h8D);
        chk("post_abort_ov",  32'(ov),  32'd1);

        // Random vectors against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref_add(8, int'(ra), int'(rb), int'(rc), es, eco, eov);
            op8(ra, rb, rc, s, co, ov, lat);
            chk($sformatf("rnd%0d_%02h_%02h_%0d_lat", i, ra, rb, rc), 32'(lat), 32'd8);
            chk($sformatf("rnd%0d_%02h_%02h_%0d_res", i, ra, rb, rc),
                {22'd0, co, ov, s}, {22'd0, 1'(eco), 1'(eov), 8'(es)});
        end

        // W=4 exhaustive
        n4_err = 0;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    ref_add(4, ia, ib, ic, es, eco, eov);
                    op4(4'(ia), 4'(ib), 1'(ic), s4, co, ov, ok);
                    chk($sformatf("w4_%0x_%0x_%0d", ia, ib, ic),
                        {25'd0, ok, co, ov, s4}, {25'd0, 1'b1, 1'(eco), 1'(eov), 4'(es)});
                    if (!ok || s4 !== 4'(es) || co !== 1'(eco) || ov !== 1'(eov)) n4_err++;
                end
        chk("w4_error_count", 32'(n4_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
